// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor resolving CHUNK bits per stage behind a valid/ready handshake.
// Optional status flags (ovf, zero, neg) are built when PIPE_ADDSUB_FLAGS_EN is defined.
module pipe_addsub #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co
`ifdef PIPE_ADDSUB_FLAGS_EN
   ,
   output logic             ovf,
   output logic             zero,
   output logic             neg
`endif
);

   localparam int unsigned STAGES = WIDTH / CHUNK;

   if ((WIDTH % CHUNK) != 0 || STAGES < 1) begin : g_bad_cfg
      $error("pipe_addsub: WIDTH must be a non-zero multiple of CHUNK");
   end

   logic             adv;
   logic [WIDTH-1:0] b_x;

   // The whole pipe moves as one; a held output freezes every stage.
   always_comb begin
      adv = !out_valid || out_ready;
   end

   assign in_ready = adv;
   assign b_x      = sub ? ~b : b;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int unsigned LO  = k * CHUNK;
      localparam int unsigned RW  = LO + CHUNK;
      localparam int unsigned REM = WIDTH - RW;

      logic [CHUNK-1:0] sl_a;
      logic [CHUNK-1:0] sl_b;
      logic             cin;
      logic             v_in;
      logic [CHUNK:0]   sum_c;
      logic [RW-1:0]    res_d;
      logic [RW-1:0]    res_q;
      logic             cy_q;
      logic             v_q;
`ifdef PIPE_ADDSUB_FLAGS_EN
      logic             z_d;
      logic             z_q;
`endif

      assign sum_c = {1'b0, sl_a} + {1'b0, sl_b} + {{CHUNK{1'b0}}, cin};

      if (k == 0) begin : g_first
         always_comb begin
            sl_a  = a[CHUNK-1:0];
            sl_b  = b_x[CHUNK-1:0];
            cin   = sub;
            v_in  = in_valid;
            res_d = sum_c[CHUNK-1:0];
`ifdef PIPE_ADDSUB_FLAGS_EN
            z_d   = (sum_c[CHUNK-1:0] == '0);
`endif
         end
      end else begin : g_next
         // Operand slice k arrives LSB-aligned in the previous stage's skew register.
         always_comb begin
            sl_a  = g_stage[k-1].g_ops.opa_q[CHUNK-1:0];
            sl_b  = g_stage[k-1].g_ops.opb_q[CHUNK-1:0];
            cin   = g_stage[k-1].cy_q;
            v_in  = g_stage[k-1].v_q;
            res_d = {sum_c[CHUNK-1:0], g_stage[k-1].res_q};
`ifdef PIPE_ADDSUB_FLAGS_EN
            z_d   = g_stage[k-1].z_q && (sum_c[CHUNK-1:0] == '0);
`endif
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            v_q   <= 1'b0;
            cy_q  <= 1'b0;
            res_q <= '0;
`ifdef PIPE_ADDSUB_FLAGS_EN
            z_q   <= 1'b0;
`endif
         end else if (adv) begin
            v_q   <= v_in;
            cy_q  <= sum_c[CHUNK];
            res_q <= res_d;
`ifdef PIPE_ADDSUB_FLAGS_EN
            z_q   <= z_d;
`endif
         end
      end

      if (k < STAGES - 1) begin : g_ops
         logic [REM-1:0] opa_d;
         logic [REM-1:0] opb_d;
         logic [REM-1:0] opa_q;
         logic [REM-1:0] opb_q;

         if (k == 0) begin : g_src_in
            always_comb begin
               opa_d = a[WIDTH-1:CHUNK];
               opb_d = b_x[WIDTH-1:CHUNK];
            end
         end else begin : g_src_prev
            always_comb begin
               opa_d = g_stage[k-1].g_ops.opa_q[REM+CHUNK-1:CHUNK];
               opb_d = g_stage[k-1].g_ops.opb_q[REM+CHUNK-1:CHUNK];
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               opa_q <= '0;
               opb_q <= '0;
            end else if (adv) begin
               opa_q <= opa_d;
               opb_q <= opb_d;
            end
         end
      end

`ifdef PIPE_ADDSUB_FLAGS_EN
      if (k == STAGES - 1) begin : g_last
         logic ovf_d;
         logic neg_d;
         logic ovf_q;
         logic neg_q;

         // Final slice carries both operand MSBs and the result MSB.
         always_comb begin
            ovf_d = (sl_a[CHUNK-1] == sl_b[CHUNK-1]) && (sum_c[CHUNK-1] != sl_a[CHUNK-1]);
            neg_d = sum_c[CHUNK-1];
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_q <= 1'b0;
               neg_q <= 1'b0;
            end else if (adv) begin
               ovf_q <= ovf_d;
               neg_q <= neg_d;
            end
         end
      end
`endif
   end

   assign out_valid = g_stage[STAGES-1].v_q;
   assign s         = g_stage[STAGES-1].res_q;
   assign co        = g_stage[STAGES-1].cy_q;
`ifdef PIPE_ADDSUB_FLAGS_EN
   assign ovf       = g_stage[STAGES-1].g_last.ovf_q;
   assign neg       = g_stage[STAGES-1].g_last.neg_q;
   assign zero      = g_stage[STAGES-1].z_q;
`endif

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub (WIDTH=32, CHUNK=8): directed table, streaming,
// backpressure, random handshake traffic and mid-flight reset against an arithmetic model.
module tb_pipe_addsub;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] s;
   logic        co;
`ifdef PIPE_ADDSUB_FLAGS_EN
   logic        ovf;
   logic        zero;
   logic        neg;
`endif

   pipe_addsub #(.WIDTH(32), .CHUNK(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .co        (co)
`ifdef PIPE_ADDSUB_FLAGS_EN
      ,
      .ovf       (ovf),
      .zero      (zero),
      .neg       (neg)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] s;
      logic        co;
      logic        z;
      logic        n;
      logic        o;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      exp_t        e;
   } vec_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   pops = 0;
   int   pushes = 0;
   int   first_pop_cyc = -1;
   int   last_pop_cyc = -1;

   // Reference: plain integer arithmetic, signed overflow from 64-bit range test.
   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic op);
      exp_t   e;
      longint sx;
      longint sy;
      longint r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (op) begin
         e.s  = x - y;
         e.co = (x >= y);
         r    = sx - sy;
      end else begin
         {e.co, e.s} = {1'b0, x} + {1'b0, y};
         r           = sx + sy;
      end
      e.z = (e.s == 32'd0);
      e.n = e.s[31];
      e.o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      return e;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic check_out(input string nm, input exp_t e);
      check({nm, ".s"}, s, e.s);
      check({nm, ".co"}, 32'(co), 32'(e.co));
`ifdef PIPE_ADDSUB_FLAGS_EN
      check({nm, ".zero"}, 32'(zero), 32'(e.z));
      check({nm, ".neg"}, 32'(neg), 32'(e.n));
      check({nm, ".ovf"}, 32'(ovf), 32'(e.o));
`endif
   endtask

   // One clock: drive at negedge, then judge the handshake that the next posedge will commit.
   task automatic cycle(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                        input logic isub, input logic ordy);
      exp_t e;
      logic exp_ready;
      @(negedge clk);
      in_valid  = iv;
      a         = ia;
      b         = ib;
      sub       = isub;
      out_ready = ordy;
      #1;
      cyc++;
      exp_ready = !out_valid || out_ready;
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      if (out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_out: got s=%h with nothing outstanding (cycle %0d)", s, cyc);
         end else begin
            e = sb_q.pop_front();
            check_out("result", e);
            pops++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
         end
      end
      if (in_valid && exp_ready) begin
         sb_q.push_back(model(a, b, sub));
         pushes++;
      end
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (sb_q.size() > 0 && guard < 40) begin
         cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
         guard++;
      end
      check("drain_left", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t        tbl[6];
      int          lat;
      logic        got;
      logic [31:0] held_s;
      logic        held_co;

      tbl[0] = '{32'h000000FF, 32'h00000001, 1'b0, '{32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0}};
      tbl[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, '{32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0}};
      tbl[2] = '{32'h00000005, 32'h00000007, 1'b1, '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0}};
      tbl[3] = '{32'h80000000, 32'h00000001, 1'b1, '{32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1}};
      tbl[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, '{32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1}};
      tbl[5] = '{32'h12345678, 32'h12345678, 1'b1, '{32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0}};

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.s", s, 32'd0);
      check("rst.co", 32'(co), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("post_rst.in_ready", 32'(in_ready), 32'd1);

      // Directed table: single beats with latency measurement.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         in_valid = 1'b1; a = tbl[i].a; b = tbl[i].b; sub = tbl[i].sub; out_ready = 1'b1;
         #1;
         check("vec.in_ready", 32'(in_ready), 32'd1);
         lat = 0;
         got = 1'b0;
         while (!got && lat < 20) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            lat++;
            if (out_valid) got = 1'b1;
         end
         check("vec.latency", 32'(lat), 32'd4);
         check_out("vec", tbl[i].e);
      end
      @(negedge clk);

      // Back-to-back streaming: 16 beats, results must come out on 16 consecutive cycles.
      pops = 0; pushes = 0; first_pop_cyc = -1; last_pop_cyc = -1;
      for (int i = 0; i < 16; i++)
         cycle(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
      drain();
      check("stream.count", 32'(pops), 32'd16);
      check("stream.span", 32'(last_pop_cyc - first_pop_cyc), 32'd15);

      // Backpressure with a full pipe.
      pops = 0; pushes = 0;
      for (int i = 0; i < 5; i++)
         cycle(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
      held_s  = s;
      held_co = co;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
         if (i == 0) begin
            held_s  = s;
            held_co = co;
         end
         check("bp.out_valid", 32'(out_valid), 32'd1);
         check("bp.in_ready", 32'(in_ready), 32'd0);
         check("bp.hold_s", s, held_s);
         check("bp.hold_co", 32'(co), 32'(held_co));
      end
      cycle(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
      check("bp.release_s", s, held_s);
      for (int i = 0; i < 3; i++)
         cycle(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
      drain();
      check("bp.no_loss", 32'(pops), 32'(pushes));

      // Random handshake traffic.
      pops = 0; pushes = 0;
      for (int i = 0; i < 300; i++)
         cycle(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) != 0));
      drain();
      check("rand.no_loss", 32'(pops), 32'(pushes));

      // Reset mid-flight: three accepted beats must vanish.
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 32'hFFFF0000 | 32'(i), 32'h00001234, 1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      sb_q.delete();
      check("mid_rst.out_valid", 32'(out_valid), 32'd0);
      check("mid_rst.s", s, 32'd0);
      check("mid_rst.co", 32'(co), 32'd0);
      check("mid_rst.in_ready", 32'(in_ready), 32'd1);
`ifdef PIPE_ADDSUB_FLAGS_EN
      check("mid_rst.flags", 32'({ovf, zero, neg}), 32'd0);
`endif
      for (int i = 0; i < 10; i++)
         cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
